serial_chunk_adder: RTL and testbench



---
 rtl/serial_chunk_adder.sv | 183 ++++++++++++++++++
 tb/tb_serial_chunk_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_chunk_adder
// Purpose  : Multi-cycle add/subtract of two WIDTH-bit operands. Each clock
//            processes CHUNK bits through one narrow ripple chain, and a
//            registered carry links consecutive chunks. Valid/ready handshakes
//            are used on both the operand side and the result side.
// Revision : 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   // Number of chunk steps per operation, and the step counter width
   // (kept at least one bit wide so that STEPS=1 still has a legal counter).
   localparam int C_STEPS  = WIDTH / CHUNK;
   localparam int C_STEP_W = (C_STEPS > 1) ? $clog2(C_STEPS) : 1;
   localparam logic [C_STEP_W-1:0] C_LAST_STEP = C_STEP_W'(C_STEPS - 1);

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_RUN  = 2'd1;
   localparam logic [1:0] C_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;

   // Operand A and the effective operand B (already inverted for subtract).
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic                r_carry;
   logic [C_STEP_W-1:0] r_step;

   logic [WIDTH-1:0]    r_sum;
   logic                r_cout;
   logic                r_ovf;
   logic                r_zero;

   logic                w_accept;
   logic                w_last;
   logic [CHUNK-1:0]    w_a_chunk;
   logic [CHUNK-1:0]    w_b_chunk;
   logic [CHUNK:0]      w_chunk_full;
   logic [CHUNK-1:0]    w_s;
   logic                w_c;
   logic [WIDTH-1:0]    w_new_sum;

   assign w_accept = (r_state == C_IDLE) && in_valid;
   assign w_last   = (r_step == C_LAST_STEP);

   // State register: reset drops any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last
   // chunk, and DONE -> IDLE when the consumer takes the result.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         C_IDLE: begin
            if (in_valid) begin
               w_next_state = C_RUN;
            end
         end
         C_RUN: begin
            if (w_last) begin
               w_next_state = C_DONE;
            end
         end
         C_DONE: begin
            if (out_ready) begin
               w_next_state = C_IDLE;
            end
         end
         default: begin
            w_next_state = C_IDLE;
         end
      endcase
   end

   // Handshake outputs are decoded straight from the state register.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         C_IDLE:  in_ready  = 1'b1;
         C_DONE:  out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Select the operand chunk addressed by the step counter.
   always_comb begin
      w_a_chunk = '0;
      w_b_chunk = '0;
      for (int i = 0; i < C_STEPS; i++) begin
         if (r_step == C_STEP_W'(i)) begin
            w_a_chunk = r_a[i*CHUNK +: CHUNK];
            w_b_chunk = r_b[i*CHUNK +: CHUNK];
         end
      end
   end

   // The single narrow ripple chain shared by every step.
   assign w_chunk_full = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
   assign w_s          = w_chunk_full[CHUNK-1:0];
   assign w_c          = w_chunk_full[CHUNK];

   // Merge the current chunk result into the running sum. This merged value
   // is also what the zero flag inspects on the final step.
   always_comb begin
      w_new_sum = r_sum;
      for (int i = 0; i < C_STEPS; i++) begin
         if (r_step == C_STEP_W'(i)) begin
            w_new_sum[i*CHUNK +: CHUNK] = w_s;
         end
      end
   end

   // Datapath: capture operands on accept, then fold in one chunk per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_step  <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_carry <= sub ? 1'b1 : cin;
         r_step  <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (r_state == C_RUN) begin
         r_sum   <= w_new_sum;
         r_carry <= w_c;
         if (w_last) begin
            r_cout <= w_c;
            // Signed overflow: the operands agree in sign but the result does not.
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[CHUNK-1] != r_a[WIDTH-1]);
            r_zero <= (w_new_sum == '0);
         end else begin
            r_step <= r_step + C_STEP_W'(1);
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;
   assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_chunk_adder
// Purpose  : Directed and sweep checks of serial_chunk_adder in three shapes:
//            8/4 (directed), 4/1 (full sweep) and 8/8 (strided sweep).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_chunk_adder;

   logic clk;
   logic rst_n;

   // 8-bit operands, 4-bit chunks
   logic       m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready;
   logic [7:0] m_a, m_b, m_sum;
   logic       m_cout, m_ovf, m_zero;

   // 4-bit operands, 1-bit chunks
   logic       x_in_valid, x_in_ready, x_cin, x_sub, x_out_valid, x_out_ready;
   logic [3:0] x_a, x_b, x_sum;
   logic       x_cout, x_ovf, x_zero;

   // 8-bit operands, single 8-bit chunk
   logic       y_in_valid, y_in_ready, y_cin, y_sub, y_out_valid, y_out_ready;
   logic [7:0] y_a, y_b, y_sum;
   logic       y_cout, y_ovf, y_zero;

   int n_pass  = 0;
   int n_total = 0;

   serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_m (
      .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub), .out_valid(m_out_valid),
      .out_ready(m_out_ready), .sum(m_sum), .cout(m_cout), .ovf(m_ovf), .zero(m_zero)
   );

   serial_chunk_adder #(.WIDTH(4), .CHUNK(1)) u_x (
      .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(x_out_valid),
      .out_ready(x_out_ready), .sum(x_sum), .cout(x_cout), .ovf(x_ovf), .zero(x_zero)
   );

   serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_y (
      .clk(clk), .rst_n(rst_n), .in_valid(y_in_valid), .in_ready(y_in_ready),
      .a(y_a), .b(y_b), .cin(y_cin), .sub(y_sub), .out_valid(y_out_valid),
      .out_ready(y_out_ready), .sum(y_sum), .cout(y_cout), .ovf(y_ovf), .zero(y_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Full-width behavioural reference: returns {cout, ovf, zero, sum[7:0]}.
   function automatic logic [10:0] model(input int w, input int ta, input int tb,
                                         input logic tc, input logic ts);
      int   mask, beff, full, s;
      logic c, o, z;
      mask = (1 << w) - 1;
      beff = ts ? (~tb & mask) : tb;
      full = ta + beff + (ts ? 1 : int'(tc));
      s    = full & mask;
      c    = full[w];
      o    = (ta[w-1] == beff[w-1]) && (s[w-1] != ta[w-1]);
      z    = (s == 0);
      return {c, o, z, s[7:0]};
   endfunction

   task automatic m_accept(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
      @(negedge clk);
      check("m_ready_before_accept", {31'd0, m_in_ready}, 32'd1);
      m_a = ta; m_b = tb; m_cin = tc; m_sub = ts; m_in_valid = 1'b1;
      @(negedge clk);
      m_in_valid = 1'b0;
   endtask

   // Counts clock edges after the accept edge until out_valid, with a bound.
   task automatic m_wait(output int lat);
      lat = 0;
      while (!m_out_valid && lat < 16) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic m_consume();
      m_out_ready = 1'b1;
      @(negedge clk);
      m_out_ready = 1'b0;
      check("m_after_handoff", {30'd0, m_out_valid, m_in_ready}, 32'b01);
   endtask

   task automatic m_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic ts, input logic [7:0] es,
                       input logic ec, input logic eo, input logic ez);
      int lat;
      m_accept(ta, tb, tc, ts);
      m_wait(lat);
      check({tag, "_lat"}, lat, 32'd2);
      check({tag, "_res"}, {21'd0, m_cout, m_ovf, m_zero, m_sum}, {21'd0, ec, eo, ez, es});
      m_consume();
   endtask

   task automatic x_op(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic ts, output logic [31:0] res);
      int lat;
      @(negedge clk);
      x_a = ta; x_b = tb; x_cin = tc; x_sub = ts; x_in_valid = 1'b1;
      @(negedge clk);
      x_in_valid = 1'b0;
      lat = 0;
      while (!x_out_valid && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      res = {lat[15:0], 5'd0, x_cout, x_ovf, x_zero, 4'd0, x_sum};
      x_out_ready = 1'b1;
      @(negedge clk);
      x_out_ready = 1'b0;
   endtask

   task automatic y_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic ts, output logic [31:0] res);
      int lat;
      @(negedge clk);
      y_a = ta; y_b = tb; y_cin = tc; y_sub = ts; y_in_valid = 1'b1;
      @(negedge clk);
      y_in_valid = 1'b0;
      lat = 0;
      while (!y_out_valid && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      res = {lat[15:0], 5'd0, y_cout, y_ovf, y_zero, y_sum};
      y_out_ready = 1'b1;
      @(negedge clk);
      y_out_ready = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [31:0] res;

      rst_n = 1'b0;
      m_in_valid = 0; m_a = 0; m_b = 0; m_cin = 0; m_sub = 0; m_out_ready = 0;
      x_in_valid = 0; x_a = 0; x_b = 0; x_cin = 0; x_sub = 0; x_out_ready = 0;
      y_in_valid = 0; y_a = 0; y_b = 0; y_cin = 0; y_sub = 0; y_out_ready = 0;

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_m", {19'd0, m_sum, m_cout, m_ovf, m_zero, m_out_valid, m_in_ready}, 32'd1);
      check("reset_xy", {28'd0, x_out_valid, x_in_ready, y_out_valid, y_in_ready}, 32'b0101);

      // Directed vectors, 8/4
      m_op("add_3c_05",   8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
      m_op("add_0f_01",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
      m_op("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      m_op("add_7f_cin",  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      m_op("sub_05_07",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      m_op("sub_80_01",   8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      m_op("sub_equal",   8'hA5, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

      // Backpressure: result held while new operands wait on in_valid
      m_accept(8'h12, 8'h34, 1'b0, 1'b0);
      m_wait(lat);
      check("bp_lat", lat, 32'd2);
      m_a = 8'h55; m_b = 8'h22; m_cin = 1'b0; m_sub = 1'b0; m_in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold", {19'd0, m_cout, m_ovf, m_zero, m_out_valid, m_in_ready, m_sum},
               {19'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h46});
         @(negedge clk);
      end
      m_out_ready = 1'b1;
      @(negedge clk);
      m_out_ready = 1'b0;
      check("bp_release", {30'd0, m_out_valid, m_in_ready}, 32'b01);
      @(negedge clk);
      m_in_valid = 1'b0;
      check("bp_next_accepted", {31'd0, m_in_ready}, 32'd0);
      m_wait(lat);
      check("bp_next_lat", lat, 32'd2);
      check("bp_next_res", {24'd0, m_sum}, 32'h77);
      m_consume();

      // Reset while RUN aborts the operation
      m_accept(8'h11, 8'h22, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_run_valid", {31'd0, m_out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_run_idle", {22'd0, m_out_valid, m_in_ready, m_sum}, {22'd0, 1'b0, 1'b1, 8'h00});
      repeat (4) @(negedge clk);
      check("rst_run_stays_idle", {30'd0, m_out_valid, m_in_ready}, 32'b01);

      // Exhaustive sweep, 4/1
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 4; k++) begin
               x_op(4'(i), 4'(j), k[0], k[1], res);
               check("sweep_4x1", res, {16'd4, 5'd0, model(4, i, j, k[0], k[1])});
            end
         end
      end

      // Strided sweep, 8/8 (latency 1)
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 4; k++) begin
               int ta, tb;
               ta = i * 17;
               tb = (j * 23 + 5) & 255;
               y_op(8'(ta), 8'(tb), k[0], k[1], res);
               check("sweep_8x8", res, {16'd1, 5'd0, model(8, ta, tb, k[0], k[1])});
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
